// File: rtl/pad_game_pkg.sv
// rtl/pad_game_pkg.sv - shared constants for the drum-pad reaction game
package pad_game_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PICK     = 3'd1;
  localparam logic [2:0] ST_PROMPT   = 3'd2;
  localparam logic [2:0] ST_RELEASE  = 3'd3;
  localparam logic [2:0] ST_GAMEOVER = 3'd4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [2:0] ADD_CENTRE = 3'd4;
  localparam logic [2:0] ADD_RING   = 3'd2;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/hiscore_table.sv
// rtl/hiscore_table.sv - descending high-score table with single-cycle sorted insert
module hiscore_table #(
  parameter int DEPTH   = 3,
  parameter int SCORE_W = 32,
  parameter int IW      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ins_valid,
  input  logic [SCORE_W-1:0] ins_score,
  input  logic [IW-1:0]      rd_idx,
  output logic [SCORE_W-1:0] rd_data
);

  logic [SCORE_W-1:0] entry_q [DEPTH];
  logic [SCORE_W-1:0] entry_d [DEPTH];
  logic [DEPTH-1:0]   ge;

  // ge is a prefix of ones because the table stays sorted; the new score lands after the last one
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ge[i] = (entry_q[i] >= ins_score);
    end
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    if (ins_valid && !ge[0]) begin
      entry_d[0] = ins_score;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (ins_valid && !ge[i]) begin
        entry_d[i] = ge[i-1] ? ins_score : entry_q[i-1];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == IW'(i)) rd_data = entry_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

endmodule

// File: rtl/pad_game_engine.sv
// rtl/pad_game_engine.sv - prompt/hit/release drum-pad game FSM with scoring
// High-score table is built only when PAD_GAME_HISCORE_EN is defined.
module pad_game_engine
  import pad_game_pkg::*;
#(
  parameter int NUM_PADS = 3,
  parameter int ZONES    = 5,
  parameter int ROUNDS   = 20,
  parameter int TIMEOUT  = 31000000,
  parameter int SCORE_W  = 32,
  parameter int HS_DEPTH = 3
) (
  input  logic                        iVGA_CLK,
  input  logic                        iRST_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_PADS*ZONES-1:0]   sensor_in,
  output logic [NUM_PADS-1:0]         pad_out,
  output logic [2:0]                  active_pad,
  output logic [1:0]                  anim_phase,
  output logic [SCORE_W-1:0]          points,
  output logic                        busy,
  output logic                        game_over,
  input  logic [$clog2(HS_DEPTH)-1:0] hs_idx,
  output logic [SCORE_W-1:0]          hs_data
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(ROUNDS + 1);

  logic [2:0]          state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [SCORE_W-1:0]  points_q, points_d;
  logic [RW-1:0]       round_q, round_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          active_pad_q, active_pad_d;
  logic [NUM_PADS-1:0] pad_out_q, pad_out_d;
  logic                ins_valid;
  logic [ZONES-1:0]    cur_zones;
  logic [2:0]          pick;
  logic [SCORE_W:0]    sum;
  logic                hit, centre, go;

  always_comb begin
    cur_zones = '1;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (active_pad_q == 3'(p)) cur_zones = sensor_in[p*ZONES +: ZONES];
    end
  end

  assign hit    = ~&cur_zones;
  assign centre = ~cur_zones[ZONES-1];
  assign pick   = 3'(lfsr_q % 16'(NUM_PADS));
  assign go     = start & ~abort;
  assign sum    = {1'b0, points_q} + {{(SCORE_W-2){1'b0}}, (centre ? ADD_CENTRE : ADD_RING)};

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_next(lfsr_q);
    points_d     = points_q;
    round_d      = round_q;
    cnt_d        = cnt_q;
    active_pad_d = active_pad_q;
    pad_out_d    = pad_out_q;
    ins_valid    = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAMEOVER: begin
        if (go) begin
          points_d = '0;
          round_d  = '0;
          state_d  = ST_PICK;
        end
      end
      ST_PICK: begin
        active_pad_d = pick;
        pad_out_d    = ~(NUM_PADS'(1) << pick);
        cnt_d        = '0;
        state_d      = ST_PROMPT;
      end
      ST_PROMPT: begin
        cnt_d = cnt_q + CW'(1);
        // a hit on the final window cycle still scores
        if (hit) begin
          points_d  = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
          pad_out_d = '1;
          state_d   = ST_RELEASE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          pad_out_d = '1;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (&cur_zones) begin
          round_d = round_q + RW'(1);
          if (round_d == RW'(ROUNDS)) begin
            state_d   = ST_GAMEOVER;
            ins_valid = 1'b1;
          end else begin
            state_d = ST_PICK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && busy) begin
      state_d   = ST_IDLE;
      pad_out_d = '1;
      ins_valid = 1'b0;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= LFSR_SEED;
      points_q     <= '0;
      round_q      <= '0;
      cnt_q        <= '0;
      active_pad_q <= '0;
      pad_out_q    <= '1;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      points_q     <= points_d;
      round_q      <= round_d;
      cnt_q        <= cnt_d;
      active_pad_q <= active_pad_d;
      pad_out_q    <= pad_out_d;
    end
  end

  always_comb begin
    anim_phase = 2'd0;
    if (state_q == ST_PROMPT) begin
      if (cnt_q < CW'(TIMEOUT / 3))          anim_phase = 2'd1;
      else if (cnt_q < CW'(2 * TIMEOUT / 3)) anim_phase = 2'd2;
      else                                   anim_phase = 2'd3;
    end
  end

  assign pad_out    = pad_out_q;
  assign active_pad = active_pad_q;
  assign points     = points_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_GAMEOVER);
  assign game_over  = (state_q == ST_GAMEOVER);

`ifdef PAD_GAME_HISCORE_EN
  hiscore_table #(
    .DEPTH   (HS_DEPTH),
    .SCORE_W (SCORE_W),
    .IW      ($clog2(HS_DEPTH))
  ) u_hiscore (
    .clk       (iVGA_CLK),
    .rst_n     (iRST_n),
    .ins_valid (ins_valid),
    .ins_score (points_q),
    .rd_idx    (hs_idx),
    .rd_data   (hs_data)
  );
`else
  logic unused_hs;
  assign unused_hs = ^{hs_idx, ins_valid};
  assign hs_data   = '0;
`endif

endmodule

// File: tb/tb_pad_game_engine.sv
// tb/tb_pad_game_engine.sv - directed self-checking bench for pad_game_engine
module tb_pad_game_engine;

`ifdef PAD_GAME_HISCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [14:0] sensor = 15'h7FFF;
  logic [2:0]  pad_out;
  logic [2:0]  active_pad;
  logic [1:0]  anim_phase;
  logic [31:0] points;
  logic        busy;
  logic        game_over;
  logic [1:0]  hs_idx = 2'd0;
  logic [31:0] hs_data;

  int total = 0;
  int bad = 0;

  pad_game_engine #(
    .NUM_PADS (3), .ZONES (5), .ROUNDS (3), .TIMEOUT (30), .SCORE_W (32), .HS_DEPTH (3)
  ) dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .start      (start),
    .abort      (abort),
    .sensor_in  (sensor),
    .pad_out    (pad_out),
    .active_pad (active_pad),
    .anim_phase (anim_phase),
    .points     (points),
    .busy       (busy),
    .game_over  (game_over),
    .hs_idx     (hs_idx),
    .hs_data    (hs_data)
  );

  always #5 clk = ~clk;

  task automatic wait_prompt(input string tag, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (pad_out === 3'b111 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (pad_out === 3'b111) begin
      bad++;
      $display("FAIL %s_prompt_wait: no prompt within 60 cycles", tag);
    end else begin
      ok = 1'b1;
    end
  endtask

  // kind: 0 centre, 1 ring only, 2 ring+centre, 3 no hit
  task automatic play_round(input int kind, input string tag);
    bit ok;
    int p, n;
    wait_prompt(tag, ok);
    if (!ok) return;
    if (kind == 3) begin
      n = 0;
      while (pad_out !== 3'b111 && n < 100) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end else begin
      p = int'(active_pad);
      if (kind == 0 || kind == 2) sensor[p*5+4] = 1'b0;
      if (kind == 1 || kind == 2) sensor[p*5+1] = 1'b0;
      @(negedge clk);
      sensor = 15'h7FFF;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic play_game(input int k0, input int k1, input int k2, input string tag);
    pulse_start();
    play_round(k0, tag);
    play_round(k1, tag);
    play_round(k2, tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sensor = 15'h7FFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (pad_out !== 3'b111) begin bad++; $display("FAIL rst_pad_out: got %b want 111", pad_out); end
    total++; if (active_pad !== 3'd0) begin bad++; $display("FAIL rst_active_pad: got %0d want 0", active_pad); end
    total++; if (anim_phase !== 2'd0) begin bad++; $display("FAIL rst_anim: got %0d want 0", anim_phase); end
    total++; if (points !== 32'd0) begin bad++; $display("FAIL rst_points: got %0d want 0", points); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL rst_game_over: got %b want 0", game_over); end
    total++; if (hs_data !== 32'd0) begin bad++; $display("FAIL rst_hs0: got %0d want 0", hs_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_centre_game();
    bit ok;
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL centre_busy: got %b want 1", busy); end
    wait_prompt("centre", ok);
    total++; if (anim_phase !== 2'd1) begin bad++; $display("FAIL centre_anim: got %0d want 1", anim_phase); end
    total++; if (pad_out !== ~(3'b001 << active_pad)) begin bad++; $display("FAIL centre_onecold: got %b active %0d", pad_out, active_pad); end
    total++; if (active_pad > 3'd2) begin bad++; $display("FAIL centre_pad_range: got %0d want <3", active_pad); end
    play_round(0, "centre");
    play_round(0, "centre");
    play_round(0, "centre");
    total++; if (points !== 32'd12) begin bad++; $display("FAIL centre_points: got %0d want 12", points); end
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL centre_game_over: got %b want 1", game_over); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL centre_busy_end: got %b want 0", busy); end
    hs_idx = 2'd0; #1;
    total++; if (hs_data !== (HS_EN ? 32'd12 : 32'd0)) begin bad++; $display("FAIL centre_hs0: got %0d want %0d", hs_data, HS_EN ? 12 : 0); end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    logic [1:0] exp;
    pulse_start();
    wait_prompt("timeout", ok);
    n = 0;
    while (ok && pad_out !== 3'b111 && n < 100) begin
      exp = (n < 10) ? 2'd1 : (n < 20) ? 2'd2 : 2'd3;
      total++; if (anim_phase !== exp) begin bad++; $display("FAIL timeout_anim_c%0d: got %0d want %0d", n, anim_phase, exp); end
      @(negedge clk);
      n++;
    end
    total++; if (n != 30) begin bad++; $display("FAIL timeout_len: got %0d want 30", n); end
    total++; if (anim_phase !== 2'd0) begin bad++; $display("FAIL timeout_anim_rel: got %0d want 0", anim_phase); end
    @(negedge clk);
    play_round(3, "timeout");
    play_round(3, "timeout");
    total++; if (points !== 32'd0) begin bad++; $display("FAIL timeout_points: got %0d want 0", points); end
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL timeout_game_over: got %b want 1", game_over); end
  endtask

  task automatic test_mixed();
    play_game(1, 2, 3, "mixed");
    total++; if (points !== 32'd6) begin bad++; $display("FAIL mixed_points: got %0d want 6", points); end
  endtask

  task automatic check_table(input int e0, input int e1, input int e2, input string tag);
    int exp [3];
    exp[0] = HS_EN ? e0 : 0;
    exp[1] = HS_EN ? e1 : 0;
    exp[2] = HS_EN ? e2 : 0;
    for (int i = 0; i < 3; i++) begin
      hs_idx = 2'(i); #1;
      total++; if (hs_data !== 32'(exp[i])) begin bad++; $display("FAIL %s_hs%0d: got %0d want %0d", tag, i, hs_data, exp[i]); end
    end
    hs_idx = 2'd0;
  endtask

  task automatic test_hiscore();
    do_reset();
    check_table(0, 0, 0, "hs_reset");
    play_game(1, 2, 3, "hs_g1");
    check_table(6, 0, 0, "hs_g1");
    play_game(0, 0, 0, "hs_g2");
    check_table(12, 6, 0, "hs_g2");
    play_game(2, 3, 1, "hs_g3");
    total++; if (points !== 32'd6) begin bad++; $display("FAIL hs_g3_points: got %0d want 6", points); end
    check_table(12, 6, 6, "hs_g3");
    play_game(1, 1, 3, "hs_g4");
    total++; if (points !== 32'd4) begin bad++; $display("FAIL hs_g4_points: got %0d want 4", points); end
    check_table(12, 6, 6, "hs_g4");
  endtask

  task automatic test_abort();
    bit ok;
    pulse_start();
    play_round(0, "abort");
    wait_prompt("abort", ok);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    total++; if (pad_out !== 3'b111) begin bad++; $display("FAIL abort_pad_out: got %b want 111", pad_out); end
    total++; if (points !== 32'd4) begin bad++; $display("FAIL abort_points: got %0d want 4", points); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL abort_game_over: got %b want 0", game_over); end
    check_table(12, 6, 6, "abort");
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL both_busy: got %b want 0", busy); end
    total++; if (pad_out !== 3'b111) begin bad++; $display("FAIL both_pad_out: got %b want 111", pad_out); end
  endtask

  task automatic test_nonactive_release();
    bit ok;
    int p, q;
    logic [2:0] lamp;
    pulse_start();
    wait_prompt("nonact", ok);
    p = int'(active_pad);
    q = (p + 1) % 3;
    lamp = ~(3'b001 << p);
    sensor[q*5 +: 5] = 5'b00000;
    repeat (3) @(negedge clk);
    total++; if (points !== 32'd0) begin bad++; $display("FAIL nonact_points: got %0d want 0", points); end
    total++; if (pad_out !== lamp) begin bad++; $display("FAIL nonact_pad_out: got %b want %b", pad_out, lamp); end
    sensor = 15'h7FFF;
    sensor[p*5+4] = 1'b0;
    @(negedge clk);
    total++; if (points !== 32'd4) begin bad++; $display("FAIL hold_points: got %0d want 4", points); end
    repeat (5) @(negedge clk);
    total++; if (pad_out !== 3'b111) begin bad++; $display("FAIL hold_pad_out: got %b want 111", pad_out); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy: got %b want 1", busy); end
    total++; if (anim_phase !== 2'd0) begin bad++; $display("FAIL hold_anim: got %0d want 0", anim_phase); end
    sensor = 15'h7FFF;
    @(negedge clk);
    wait_prompt("release", ok);
    pulse_start();
    total++; if (points !== 32'd4) begin bad++; $display("FAIL busy_start_points: got %0d want 4", points); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_start_busy: got %b want 1", busy); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL end_abort_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_centre_game();
    test_timeout();
    test_mixed();
    test_hiscore();
    test_abort();
    test_nonactive_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
